// File: rtl/pix_plane_tx.sv
// Bit-plane transmitter: reads 8-bit pixels from a buffer and sends each as eight DW-wide planes, LSB first.
// Optional macro PIX_TX_TEST_PATTERN_EN replaces buffer data with the pixel index (PIX_REN held low).
module pix_plane_tx #(
    parameter int DW  = 128,
    parameter int AW  = 10,
    parameter int GAP = 10
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RST,
    input  logic          START,
    input  logic [7:0]    PIC_SIZE,
    input  logic [AW-1:0] RDADDR_START,
    output logic          PIX_REN,
    output logic [AW-1:0] PIX_RADDR,
    input  logic [7:0]    PIX_RDATA,
    output logic [DW-1:0] DATA,
    output logic          DATA_VLD,
    input  logic          WREADY,
    output logic          DATA_SOP,
    output logic          DATA_HSYNC,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOP,
        S_LOAD,
        S_SEND,
        S_HSYNC,
        S_GAP,
        S_FIN
    } state_t;

    localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GM1 = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GM1[GW-1:0];

    state_t        state_q;
    logic [7:0]    size_q;
    logic [7:0]    col_q;
    logic [7:0]    row_q;
    logic [7:0]    pix_q;
    logic [2:0]    bit_q;
    logic [GW-1:0] gap_q;
    logic          rd_q;
    logic          fin_q;

    logic          ren_q;
    logic [AW-1:0] raddr_q;
    logic [DW-1:0] data_q;
    logic          vld_q;
    logic          sop_q;
    logic          hsync_q;
    logic          busy_q;
    logic          done_q;

    logic [7:0]    pix_in;
    logic          pix_done;
    logic          last_col;
    logic          last_row;
    logic [7:0]    col_d;
    logic [7:0]    row_d;

    assign pix_done = (state_q == S_SEND) && WREADY && (bit_q == 3'd7);
    assign last_col = (col_q == size_q - 8'd1);
    assign last_row = (row_q == size_q - 8'd1);

    always_comb begin
        col_d = col_q + 8'd1;
        row_d = row_q;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? 8'd0 : row_q + 8'd1;
        end
    end

`ifdef PIX_TX_TEST_PATTERN_EN
    localparam logic REN_ON = 1'b0;
    logic [7:0] idx_q;
    logic       unused_rdata;

    assign unused_rdata = ^PIX_RDATA;

    // Pixel index modulo 256 stands in for buffer contents.
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            idx_q <= '0;
        end else if (state_q == S_IDLE) begin
            idx_q <= '0;
        end else if (pix_done) begin
            idx_q <= idx_q + 8'd1;
        end
    end

    assign pix_in = idx_q;
`else
    localparam logic REN_ON = 1'b1;
    assign pix_in = PIX_RDATA;
`endif

    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            rd_q    <= 1'b0;
            fin_q   <= 1'b0;
            ren_q   <= 1'b0;
            raddr_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            hsync_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sop_q   <= 1'b0;
            hsync_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        busy_q <= 1'b1;
                        if (PIC_SIZE != 8'd0) begin
                            size_q  <= PIC_SIZE;
                            col_q   <= '0;
                            row_q   <= '0;
                            fin_q   <= 1'b0;
                            raddr_q <= RDADDR_START;
                            ren_q   <= REN_ON;
                            sop_q   <= 1'b1;
                            state_q <= S_SOP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_SOP: begin
                    ren_q   <= 1'b0;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    // Buffer data arrives the cycle after the read; first plane goes straight out.
                    pix_q   <= pix_in;
                    bit_q   <= '0;
                    data_q  <= {DW{pix_in[0]}};
                    vld_q   <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (WREADY) begin
                        if (bit_q != 3'd7) begin
                            bit_q  <= bit_q + 3'd1;
                            data_q <= {DW{pix_q[bit_q + 3'd1]}};
                        end else begin
                            vld_q  <= 1'b0;
                            data_q <= '0;
                            col_q  <= col_d;
                            row_q  <= row_d;
                            gap_q  <= '0;
                            if (last_col) begin
                                fin_q   <= last_row;
                                hsync_q <= 1'b1;
                                state_q <= S_HSYNC;
                            end else begin
                                state_q <= S_GAP;
                                if (GAP == 0) begin
                                    rd_q    <= 1'b1;
                                    ren_q   <= REN_ON;
                                    raddr_q <= raddr_q + AW'(1);
                                end
                            end
                        end
                    end
                end
                S_HSYNC: begin
                    if (fin_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        gap_q   <= '0;
                        state_q <= S_GAP;
                        if (GAP == 0) begin
                            rd_q    <= 1'b1;
                            ren_q   <= REN_ON;
                            raddr_q <= raddr_q + AW'(1);
                        end
                    end
                end
                S_GAP: begin
                    // Idle cycles first; the read cycle is the last one spent here.
                    if (rd_q) begin
                        rd_q    <= 1'b0;
                        ren_q   <= 1'b0;
                        state_q <= S_LOAD;
                    end else if (gap_q == GAP_LAST) begin
                        rd_q    <= 1'b1;
                        ren_q   <= REN_ON;
                        raddr_q <= raddr_q + AW'(1);
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign PIX_REN    = ren_q;
    assign PIX_RADDR  = raddr_q;
    assign DATA       = data_q;
    assign DATA_VLD   = vld_q;
    assign DATA_SOP   = sop_q;
    assign DATA_HSYNC = hsync_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_pix_plane_tx.sv
// Self-checking bench for pix_plane_tx: table of whole-frame scenarios plus hand-written reset/size-0 sequences.
module tb_pix_plane_tx;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int GAP_P = 10;
    localparam int FRAME_BUDGET = 4000;
`ifdef PIX_TX_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic          SYS_CLK;
    logic          SYS_RST;
    logic          START;
    logic [7:0]    PIC_SIZE;
    logic [AW-1:0] RDADDR_START;
    logic          PIX_REN;
    logic [AW-1:0] PIX_RADDR;
    logic [7:0]    PIX_RDATA;
    logic [DW-1:0] DATA;
    logic          DATA_VLD;
    logic          WREADY;
    logic          DATA_SOP;
    logic          DATA_HSYNC;
    logic          BUSY;
    logic          DONE;

    pix_plane_tx #(.DW(DW), .AW(AW), .GAP(GAP_P)) dut (
        .SYS_CLK(SYS_CLK),
        .SYS_RST(SYS_RST),
        .START(START),
        .PIC_SIZE(PIC_SIZE),
        .RDADDR_START(RDADDR_START),
        .PIX_REN(PIX_REN),
        .PIX_RADDR(PIX_RADDR),
        .PIX_RDATA(PIX_RDATA),
        .DATA(DATA),
        .DATA_VLD(DATA_VLD),
        .WREADY(WREADY),
        .DATA_SOP(DATA_SOP),
        .DATA_HSYNC(DATA_HSYNC),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    // Pixel buffer: buffer[k] = k (low 8 bits), one-cycle read latency.
    logic [7:0] mem [0:1023];
    always @(posedge SYS_CLK) begin
        if (PIX_REN) PIX_RDATA <= mem[PIX_RADDR];
    end

    typedef struct {
        logic [7:0]    size;
        logic [AW-1:0] start;
        int            stall_at;
        int            stall_len;
        bit            idle_low;
        bit            restart;
        int            exp_xfer;
        int            exp_hs;
    } vec_t;

    vec_t tbl[4];
    int n_chk;
    int n_pass;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] pix_val(input logic [AW-1:0] st, input int p);
        logic [AW-1:0] a;
        a = st + p[AW-1:0];
        if (TP) return p[7:0];
        return mem[a];
    endfunction

    function automatic int outs_ones();
        return $countones({DATA, DATA_VLD, DATA_SOP, DATA_HSYNC, PIX_REN, PIX_RADDR, BUSY, DONE});
    endfunction

    task automatic run_frame(input string tag, input vec_t v);
        int cyc, xfer, sop_n, hs_n, done_n, ren_n, stall_n, stall_left;
        int sop_cyc, ren_cyc, vld_cyc, gap_cnt;
        int addr_err, data_err, gap_err, hold_err, ovl_err, busy_err;
        bit gap_run, hs_in_gap, prev_stall;
        logic [DW-1:0] prev_data, exp_d;
        logic [AW-1:0] exp_a;
        logic [7:0] pv;
        cyc = 0; xfer = 0; sop_n = 0; hs_n = 0; done_n = 0; ren_n = 0; stall_n = 0;
        stall_left = v.stall_len; sop_cyc = -1; ren_cyc = -1; vld_cyc = -1; gap_cnt = 0;
        addr_err = 0; data_err = 0; gap_err = 0; hold_err = 0; ovl_err = 0; busy_err = 0;
        gap_run = 0; hs_in_gap = 0; prev_stall = 0; prev_data = '0;
        @(negedge SYS_CLK);
        PIC_SIZE = v.size;
        RDADDR_START = v.start;
        START = 1'b1;
        WREADY = v.idle_low ? 1'b0 : 1'b1;
        while (done_n == 0 && cyc < FRAME_BUDGET) begin
            @(negedge SYS_CLK);
            cyc++;
            // Inputs change after START to show the frame parameters are latched.
            PIC_SIZE = 8'hFF;
            RDADDR_START = '0;
            START = (v.restart && xfer == 20) ? 1'b1 : 1'b0;
            if (DATA_VLD && xfer == v.stall_at && stall_left > 0) begin
                WREADY = 1'b0;
                stall_left--;
            end else begin
                WREADY = (DATA_VLD || !v.idle_low) ? 1'b1 : 1'b0;
            end
            if (!BUSY) busy_err++;
            if (DATA_SOP) begin
                sop_n++;
                if (sop_cyc < 0) sop_cyc = cyc;
            end
            if (DATA_VLD && vld_cyc < 0) vld_cyc = cyc;
            if (DATA_VLD && (DATA_SOP || DATA_HSYNC || DONE)) ovl_err++;
            if (DATA_HSYNC) hs_n++;
            if (DONE) done_n++;
            if (PIX_REN) begin
                exp_a = v.start + ren_n[AW-1:0];
                if (PIX_RADDR !== exp_a) addr_err++;
                if (gap_run && gap_cnt != GAP_P + int'(hs_in_gap)) gap_err++;
                if (ren_cyc < 0) ren_cyc = cyc;
                gap_run = 0;
                ren_n++;
            end else if (gap_run) begin
                if (DATA_HSYNC) hs_in_gap = 1;
                gap_cnt++;
            end
            if (prev_stall && (DATA !== prev_data || !DATA_VLD)) hold_err++;
            if (DATA_VLD) begin
                pv = pix_val(v.start, xfer / 8);
                exp_d = {DW{pv[xfer % 8]}};
                if (DATA !== exp_d) data_err++;
                if (!WREADY) stall_n++;
                if (WREADY) begin
                    if (xfer % 8 == 7) begin
                        gap_run = 1;
                        gap_cnt = 0;
                        hs_in_gap = 0;
                    end
                    xfer++;
                end
            end
            prev_stall = DATA_VLD && !WREADY;
            prev_data = DATA;
        end
        START = 1'b0;
        WREADY = 1'b1;
        check({tag, ".done_count"}, done_n, 1);
        check({tag, ".sop_count"}, sop_n, 1);
        check({tag, ".sop_cycle"}, sop_cyc, 1);
        check({tag, ".first_vld_cycle"}, vld_cyc, 3);
        check({tag, ".first_ren_cycle"}, ren_cyc, TP ? -1 : 1);
        check({tag, ".transfers"}, xfer, v.exp_xfer);
        check({tag, ".hsync_count"}, hs_n, v.exp_hs);
        check({tag, ".reads"}, ren_n, TP ? 0 : v.exp_xfer / 8);
        check({tag, ".addr_errors"}, addr_err, 0);
        check({tag, ".data_errors"}, data_err, 0);
        check({tag, ".gap_errors"}, gap_err, 0);
        check({tag, ".stall_hold_errors"}, hold_err, 0);
        check({tag, ".stall_cycles"}, stall_n, v.stall_len);
        check({tag, ".pulse_overlap"}, ovl_err, 0);
        check({tag, ".busy_low_in_frame"}, busy_err, 0);
        @(negedge SYS_CLK);
        check({tag, ".idle_after_done"}, {31'd0, BUSY} + {31'd0, DONE}, 0);
    endtask

    initial begin
        int k, cnt;
        n_chk = 0;
        n_pass = 0;
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        //            size   start    stall_at len idle_low restart xfers hsync
        tbl[0] = '{8'd8, 10'd0,    19, 20, 1'b0, 1'b0, 512, 8};
        tbl[1] = '{8'd4, 10'd1020, -1, 0,  1'b1, 1'b0, 128, 4};
        tbl[2] = '{8'd3, 10'd5,    -1, 0,  1'b0, 1'b1, 72,  3};
        tbl[3] = '{8'd1, 10'd1023, 0,  3,  1'b1, 1'b1, 8,   1};

        SYS_RST = 1'b0;
        START = 1'b0;
        WREADY = 1'b1;
        PIC_SIZE = 8'd0;
        RDADDR_START = '0;
        repeat (3) @(negedge SYS_CLK);
        check("reset.outputs_zero", outs_ones(), 0);
        SYS_RST = 1'b1;
        @(negedge SYS_CLK);
        check("idle.outputs_zero", outs_ones(), 0);

        for (int i = 0; i < 4; i++) run_frame($sformatf("frame%0d", i), tbl[i]);

        // Empty picture: DONE only.
        @(negedge SYS_CLK);
        PIC_SIZE = 8'd0;
        START = 1'b1;
        @(negedge SYS_CLK);
        START = 1'b0;
        check("size0.done", DONE, 1);
        check("size0.no_sop_vld_ren", {30'd0, DATA_SOP} + {30'd0, DATA_VLD} + {30'd0, PIX_REN}, 0);
        @(negedge SYS_CLK);
        check("size0.done_one_cycle", DONE, 0);
        @(negedge SYS_CLK);
        check("size0.busy_released", BUSY, 0);

        // Reset asserted while pixel 10 is being sent.
        @(negedge SYS_CLK);
        PIC_SIZE = 8'd8;
        RDADDR_START = '0;
        START = 1'b1;
        @(negedge SYS_CLK);
        START = 1'b0;
        k = 0;
        cnt = 0;
        while (k < 80 && cnt < FRAME_BUDGET) begin
            @(negedge SYS_CLK);
            cnt++;
            if (DATA_VLD && WREADY) k++;
        end
        check("midrst.reached_pixel10", k, 80);
        SYS_RST = 1'b0;
        #1;
        check("midrst.async_clear", outs_ones(), 0);
        @(negedge SYS_CLK);
        check("midrst.cycle1_zero", outs_ones(), 0);
        @(negedge SYS_CLK);
        check("midrst.cycle2_zero", outs_ones(), 0);
        SYS_RST = 1'b1;
        run_frame("after_reset", tbl[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
